// File: rtl/ha1588_axi_master.sv
// ha1588_axi_master: local-bus to AXI4-Lite master bridge, one outstanding
// transaction, per-channel backpressure, error reporting and hung-slave timeout.
module ha1588_axi_master #(
  parameter int                                C_M_AXI_REG_ADDR_WIDTH = 32,
  parameter int                                C_M_AXI_REG_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_REG_ADDR_WIDTH-1:0] C_BASE_ADDR            = '0,
  parameter int                                C_TIMEOUT              = 255
) (
  input  logic                                  M_AXI_REG_ACLK,
  input  logic                                  M_AXI_REG_ARESETN,
  // local bus
  input  logic                                  up_wr,
  input  logic                                  up_rd,
  input  logic [7:0]                            up_addr,
  input  logic [31:0]                           up_data_wr,
  output logic [31:0]                           up_data_rd,
  output logic                                  up_ack,
  output logic                                  up_err,
  output logic                                  up_busy,
  // write address / data / response
  output logic [C_M_AXI_REG_ADDR_WIDTH-1:0]     M_AXI_REG_AWADDR,
  output logic [2:0]                            M_AXI_REG_AWPROT,
  output logic                                  M_AXI_REG_AWVALID,
  input  logic                                  M_AXI_REG_AWREADY,
  output logic [C_M_AXI_REG_DATA_WIDTH-1:0]     M_AXI_REG_WDATA,
  output logic [C_M_AXI_REG_DATA_WIDTH/8-1:0]   M_AXI_REG_WSTRB,
  output logic                                  M_AXI_REG_WVALID,
  input  logic                                  M_AXI_REG_WREADY,
  input  logic [1:0]                            M_AXI_REG_BRESP,
  input  logic                                  M_AXI_REG_BVALID,
  output logic                                  M_AXI_REG_BREADY,
  // read address / data
  output logic [C_M_AXI_REG_ADDR_WIDTH-1:0]     M_AXI_REG_ARADDR,
  output logic [2:0]                            M_AXI_REG_ARPROT,
  output logic                                  M_AXI_REG_ARVALID,
  input  logic                                  M_AXI_REG_ARREADY,
  input  logic [C_M_AXI_REG_DATA_WIDTH-1:0]     M_AXI_REG_RDATA,
  input  logic [1:0]                            M_AXI_REG_RRESP,
  input  logic                                  M_AXI_REG_RVALID,
  output logic                                  M_AXI_REG_RREADY
);

  // Abort fires on the edge where the counter would reach C_TIMEOUT.
  localparam bit          TO_EN   = (C_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(C_TIMEOUT - 1) : 16'd0;

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP} state_t;

  state_t                              state, state_nxt;
  logic                                aw_done, w_done;
  logic [15:0]                         cnt;
  logic [C_M_AXI_REG_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_REG_DATA_WIDTH-1:0]   wdata_q;
  logic [31:0]                         rdata_q;
  logic                                ack_q, err_q;
  logic                                ack_nxt, err_nxt, rd_cap;
  logic                                accept, timeout;
  logic                                aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // VALIDs come straight from registered state, never from READY.
  assign M_AXI_REG_AWVALID = (state == WR_ADDR_DATA) && !aw_done;
  assign M_AXI_REG_WVALID  = (state == WR_ADDR_DATA) && !w_done;
  assign M_AXI_REG_BREADY  = (state == WR_RESP);
  assign M_AXI_REG_ARVALID = (state == RD_ADDR);
  assign M_AXI_REG_RREADY  = (state == RD_RESP);

  assign M_AXI_REG_AWADDR  = addr_q;
  assign M_AXI_REG_ARADDR  = addr_q;
  assign M_AXI_REG_AWPROT  = 3'b000;
  assign M_AXI_REG_ARPROT  = 3'b000;
  assign M_AXI_REG_WDATA   = wdata_q;
  assign M_AXI_REG_WSTRB   = '1;

  assign up_data_rd = rdata_q;
  assign up_ack     = ack_q;
  assign up_err     = err_q;
  assign up_busy    = (state != IDLE);

  assign aw_hs   = M_AXI_REG_AWVALID && M_AXI_REG_AWREADY;
  assign w_hs    = M_AXI_REG_WVALID  && M_AXI_REG_WREADY;
  assign b_hs    = M_AXI_REG_BREADY  && M_AXI_REG_BVALID;
  assign ar_hs   = M_AXI_REG_ARVALID && M_AXI_REG_ARREADY;
  assign r_hs    = M_AXI_REG_RREADY  && M_AXI_REG_RVALID;
  assign accept  = (state == IDLE) && (up_wr || up_rd);
  assign timeout = TO_EN && (state != IDLE) && (cnt == TO_LAST);

  // Next-state and completion strobes; timeout overrides any channel progress.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rd_cap    = 1'b0;
    case (state)
      IDLE: begin
        if (up_wr)      state_nxt = WR_ADDR_DATA;
        else if (up_rd) state_nxt = RD_ADDR;
      end
      WR_ADDR_DATA: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
          err_nxt   = (M_AXI_REG_BRESP != 2'b00);
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b1;
          err_nxt   = (M_AXI_REG_RRESP != 2'b00);
          rd_cap    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt = IDLE;
      ack_nxt   = 1'b1;
      err_nxt   = 1'b1;
      rd_cap    = 1'b0;
    end
  end

  // State, channel-done flags, timeout counter and latched request/response data.
  always_ff @(posedge M_AXI_REG_ACLK or negedge M_AXI_REG_ARESETN) begin
    if (!M_AXI_REG_ARESETN) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        cnt     <= '0;
        addr_q  <= C_BASE_ADDR | C_M_AXI_REG_ADDR_WIDTH'(up_addr);
        if (up_wr) wdata_q <= C_M_AXI_REG_DATA_WIDTH'(up_data_wr);
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (state != IDLE) cnt <= cnt + 16'd1;
      end
      if (rd_cap) rdata_q <= 32'(M_AXI_REG_RDATA);
    end
  end

endmodule

// File: tb/tb_ha1588_axi_master.sv
// tb_ha1588_axi_master: table-driven and randomized checks of the AXI4-Lite
// master against a transaction-level timing model and an in-bench slave.
module tb_ha1588_axi_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_wr = 0, up_rd = 0;
  logic [7:0]  up_addr = 0;
  logic [31:0] up_data_wr = 0;
  logic [31:0] up_data_rd;
  logic        up_ack, up_err, up_busy;
  logic [31:0] awaddr, wdata, araddr, rdata = 0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0]  bresp = 0, rresp = 0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ha1588_axi_master #(
    .C_M_AXI_REG_ADDR_WIDTH(32), .C_M_AXI_REG_DATA_WIDTH(32),
    .C_BASE_ADDR(BASE), .C_TIMEOUT(TO)
  ) dut (
    .M_AXI_REG_ACLK(clk), .M_AXI_REG_ARESETN(rst_n),
    .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_data_wr(up_data_wr),
    .up_data_rd(up_data_rd), .up_ack(up_ack), .up_err(up_err), .up_busy(up_busy),
    .M_AXI_REG_AWADDR(awaddr), .M_AXI_REG_AWPROT(awprot), .M_AXI_REG_AWVALID(awvalid),
    .M_AXI_REG_AWREADY(awready), .M_AXI_REG_WDATA(wdata), .M_AXI_REG_WSTRB(wstrb),
    .M_AXI_REG_WVALID(wvalid), .M_AXI_REG_WREADY(wready), .M_AXI_REG_BRESP(bresp),
    .M_AXI_REG_BVALID(bvalid), .M_AXI_REG_BREADY(bready), .M_AXI_REG_ARADDR(araddr),
    .M_AXI_REG_ARPROT(arprot), .M_AXI_REG_ARVALID(arvalid), .M_AXI_REG_ARREADY(arready),
    .M_AXI_REG_RDATA(rdata), .M_AXI_REG_RRESP(rresp), .M_AXI_REG_RVALID(rvalid),
    .M_AXI_REG_RREADY(rready)
  );

  // d1: AW/AR ready delay, d2: W ready delay, d3: B/R valid delay (cycles).
  typedef struct {
    bit          wr;
    bit          both;
    logic [7:0]  off;
    logic [31:0] data;
    int          d1;
    int          d2;
    int          d3;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_edge;
    bit          exp_err;
    logic [31:0] exp_rd;
    bit          exp_to;
  } txn_t;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (txn %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Completion edge from handshake arithmetic: VALID rises in cycle 1, a
  // READY raised after d cycles meets it at edge d+1, response follows.
  function automatic txn_t model(input txn_t t, input logic [31:0] prev_rd);
    int done;
    done = t.wr ? ((t.d1 > t.d2 ? t.d1 : t.d2) + 2 + t.d3) : (t.d1 + 2 + t.d3);
    t.exp_to   = (TO != 0) && (done >= TO);
    t.exp_edge = t.exp_to ? TO : done;
    t.exp_err  = t.exp_to || (t.resp != 2'b00);
    t.exp_rd   = (!t.wr && !t.exp_to) ? t.rdata : prev_rd;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input int id);
    int aw_e = 0, w_e = 0, ar_e = 0, n_aw = 0, n_b = 0, n_ar = 0, n_arv = 0, n_r = 0;
    int n_ack = 0, ack_edge = -1;
    logic [31:0] exp_addr;
    exp_addr = BASE | {24'h0, t.off};
    @(negedge clk);
    up_wr = t.wr; up_rd = !t.wr || t.both; up_addr = t.off; up_data_wr = t.data;
    bresp = t.resp; rresp = t.resp; rdata = t.rdata;
    @(posedge clk); #1;
    up_wr = 0; up_rd = 0;
    for (int k = 1; k <= 14; k++) begin
      awready = t.wr && (k > t.d1);
      wready  = t.wr && (k > t.d2);
      arready = !t.wr && (k > t.d1);
      bvalid  = t.wr && aw_e > 0 && w_e > 0 && n_b == 0 && (k > ((aw_e > w_e ? aw_e : w_e) + t.d3));
      rvalid  = !t.wr && ar_e > 0 && n_r == 0 && (k > ar_e + t.d3);
      up_rd   = t.both && (k == 2);
      @(negedge clk);
      if (k == 1) chk("busy_after_accept", id, 32'(up_busy), 32'd1);
      if (awvalid && awready) begin
        n_aw++; aw_e = k;
        chk("awaddr", id, awaddr, exp_addr);
        chk("awprot", id, 32'(awprot), 32'd0);
      end
      if (wvalid && wready) begin
        w_e = k;
        chk("wdata", id, wdata, t.data);
        chk("wstrb", id, 32'(wstrb), 32'hF);
      end
      if (bvalid && bready) n_b++;
      if (arvalid) n_arv++;
      if (arvalid && arready) begin
        n_ar++; ar_e = k;
        chk("araddr", id, araddr, exp_addr);
        chk("arprot", id, 32'(arprot), 32'd0);
      end
      if (rvalid && rready) n_r++;
      if (up_ack) begin
        n_ack++;
        if (ack_edge < 0) ack_edge = k - 1;
        chk("err", id, 32'(up_err), 32'(t.exp_err));
        chk("busy_at_ack", id, 32'(up_busy), 32'd0);
        chk("valids_at_ack", id, 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
      end
      @(posedge clk); #1;
    end
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; up_rd = 0;
    chk("ack_count", id, 32'(n_ack), 32'd1);
    chk("ack_edge", id, 32'(ack_edge), 32'(t.exp_edge));
    chk("data_rd", id, up_data_rd, t.exp_rd);
    if (t.wr) begin
      chk("aw_beats", id, 32'(n_aw), t.exp_to ? 32'd0 : 32'd1);
      chk("b_beats", id, 32'(n_b), t.exp_to ? 32'd0 : 32'd1);
      chk("no_arvalid", id, 32'(n_arv), 32'd0);
    end else begin
      chk("ar_beats", id, 32'(n_ar), t.exp_to ? 32'd0 : 32'd1);
      chk("r_beats", id, 32'(n_r), t.exp_to ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    txn_t tbl[$];
    txn_t t;
    logic [31:0] last_rd;
    int id = 0;
    int acks;

    // wr both off data d1 d2 d3 resp rdata | edge err rd to
    tbl.push_back('{1, 0, 8'h10, 32'h1234_5678, 0,  0, 0, 2'b00, 32'h0,         2, 0, 32'h0,         0});
    tbl.push_back('{0, 0, 8'h24, 32'h0,         0,  0, 3, 2'b00, 32'hCAFE_F00D, 5, 0, 32'hCAFE_F00D, 0});
    tbl.push_back('{1, 0, 8'h3C, 32'hDEAD_BEEF, 3,  0, 0, 2'b00, 32'h0,         5, 0, 32'hCAFE_F00D, 0});
    tbl.push_back('{1, 0, 8'h04, 32'h0000_0001, 0,  0, 0, 2'b10, 32'h0,         2, 1, 32'hCAFE_F00D, 0});
    tbl.push_back('{0, 0, 8'h08, 32'h0,         0,  0, 0, 2'b11, 32'h0000_0055, 2, 1, 32'h0000_0055, 0});
    tbl.push_back('{1, 0, 8'h40, 32'h0000_0077, 99, 0, 0, 2'b00, 32'h0,         8, 1, 32'h0000_0055, 1});
    tbl.push_back('{0, 0, 8'h0C, 32'h0,         1,  0, 1, 2'b00, 32'hA5A5_0001, 4, 0, 32'hA5A5_0001, 0});
    tbl.push_back('{1, 1, 8'h20, 32'h0BAD_F00D, 0,  0, 1, 2'b00, 32'h0,         3, 0, 32'hA5A5_0001, 0});
    tbl.push_back('{1, 0, 8'hFF, 32'h1111_2222, 1,  2, 0, 2'b11, 32'h0,         4, 1, 32'hA5A5_0001, 0});

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valids", id, 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
    chk("rst_awaddr", id, awaddr, 32'd0);
    chk("rst_araddr", id, araddr, 32'd0);
    chk("rst_wdata", id, wdata, 32'd0);
    chk("rst_data_rd", id, up_data_rd, 32'd0);
    chk("rst_ack_err_busy", id, 32'({up_ack, up_err, up_busy}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      id++;
      run_txn(tbl[i], id);
    end

    // reset asserted while waiting for R: outputs clear without a clock edge
    id++;
    @(negedge clk);
    up_rd = 1; up_addr = 8'h30;
    @(posedge clk); #1;
    up_rd = 0; arready = 1;
    @(posedge clk); #1;
    arready = 0;
    @(negedge clk);
    chk("rready_before_rst", id, 32'(rready), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rready_after_rst", id, 32'(rready), 32'd0);
    chk("busy_after_rst", id, 32'(up_busy), 32'd0);
    chk("ack_after_rst", id, 32'(up_ack), 32'd0);
    chk("data_rd_after_rst", id, up_data_rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (up_ack) acks++;
    end
    chk("no_ack_after_rst", id, 32'(acks), 32'd0);
    @(posedge clk); #1;
    last_rd = 32'h0;

    // randomized transactions against the timing model
    for (int n = 0; n < 40; n++) begin
      id++;
      t.wr    = 1'($urandom_range(0, 1));
      t.both  = 0;
      t.off   = 8'($urandom);
      t.data  = $urandom;
      t.d1    = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 2));
      t.d2    = $urandom_range(0, 2);
      t.d3    = t.wr ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      t.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t.rdata = $urandom;
      t = model(t, last_rd);
      last_rd = t.exp_rd;
      run_txn(t, id);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
